alarm_ctrl: RTL and testbench

Alarm controller that consumes the four BCD time digits produced by the watch counter and compares them against a user-set alarm time. On a match it drives a ring output through a small state machine with timed ring, stop and snooze handling. It runs on the same clk as the watch counter, which is one tick per second. Its outputs feed the buzzer driver and the status LEDs.

---
 rtl/alarm_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alarm_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: compares BCD watch time against a user-set alarm time and runs a small
// IDLE / RINGING / SNOOZE state machine driving the buzzer and status LEDs.
// Optional feature macro: ALARM_SNOOZE_EN enables the snooze button, SNOOZE state and
// snooze counters. Without it, RINGING exits only on stop, alarm disable or timeout.
module alarm_ctrl #(
  parameter int unsigned RING_CYCLES   = 60,
  parameter int unsigned SNOOZE_CYCLES = 300,
  parameter int unsigned MAX_SNOOZE    = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] i_hourdec_now,
  input  logic [3:0] i_hourone_now,
  input  logic [3:0] i_mindec_now,
  input  logic [3:0] i_minone_now,
  input  logic [3:0] i_hourdec_alm,
  input  logic [3:0] i_hourone_alm,
  input  logic [3:0] i_mindec_alm,
  input  logic [3:0] i_minone_alm,
  input  logic       i_alarm_en,
  input  logic       i_stop_btn,
  input  logic       i_snooze_btn,
  output logic       o_ring,
  output logic       o_snoozing,
  output logic [1:0] o_state,
  output logic [1:0] o_snooze_cnt
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRinging = 2'b01,
    StSnooze  = 2'b10,
    StUnused  = 2'b11
  } state_e;

  localparam int unsigned RW = $clog2(RING_CYCLES + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_CYCLES - 1);
  localparam logic [RW-1:0] RING_ONE  = RW'(1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [RW-1:0] r_ring_cnt;
  logic [RW-1:0] w_ring_cnt_nxt;
  logic          r_match_q;
  logic          r_stop_q;
  logic          w_match;
  logic          w_match_rise;
  logic          w_stop_ev;

  // Raw digit compare; invalid BCD alarm digits simply never match valid time.
  assign w_match = (i_hourdec_now == i_hourdec_alm) && (i_hourone_now == i_hourone_alm) &&
                   (i_mindec_now  == i_mindec_alm)  && (i_minone_now  == i_minone_alm);
  assign w_match_rise = w_match & ~r_match_q;
  assign w_stop_ev    = i_stop_btn & ~r_stop_q;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SW = $clog2(SNOOZE_CYCLES + 1);
  localparam logic [SW-1:0] SN_LAST = SW'(SNOOZE_CYCLES - 1);
  localparam logic [SW-1:0] SN_ONE  = SW'(1);

  logic          r_snz_q;
  logic          w_snz_ev;
  logic [SW-1:0] r_sn_cnt;
  logic [SW-1:0] w_sn_cnt_nxt;
  logic [1:0]    r_snooze_cnt;
  logic [1:0]    w_snooze_cnt_nxt;

  assign w_snz_ev = i_snooze_btn & ~r_snz_q;

  // Snooze button history and snooze counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_snz_q      <= 1'b0;
      r_sn_cnt     <= '0;
      r_snooze_cnt <= 2'd0;
    end else begin
      r_snz_q      <= i_snooze_btn;
      r_sn_cnt     <= w_sn_cnt_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
    end
  end
`else
  // Snooze hardware is absent; keep its inputs and parameters visibly consumed.
  logic w_unused_snooze;
  assign w_unused_snooze = i_snooze_btn ^ (SNOOZE_CYCLES == 0) ^ (MAX_SNOOZE == 0);
`endif

  // State register, ring counter, match history (reset to 1 to mask a match at release)
  // and stop button history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StIdle;
      r_ring_cnt <= '0;
      r_match_q  <= 1'b1;
      r_stop_q   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_match_q  <= w_match;
      r_stop_q   <= i_stop_btn;
    end
  end

  // Next-state and counter updates, priorities highest first within each state.
  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
`ifdef ALARM_SNOOZE_EN
    w_sn_cnt_nxt     = r_sn_cnt;
    w_snooze_cnt_nxt = r_snooze_cnt;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_alarm_en && w_match_rise) begin
          w_state_nxt    = StRinging;
          w_ring_cnt_nxt = '0;
`ifdef ALARM_SNOOZE_EN
          w_snooze_cnt_nxt = 2'd0;
`endif
        end
      end
      StRinging: begin
        if (!i_alarm_en) begin
          w_state_nxt = StIdle;
        end else if (w_stop_ev) begin
          w_state_nxt = StIdle;
`ifdef ALARM_SNOOZE_EN
        end else if (w_snz_ev && ({30'd0, r_snooze_cnt} < MAX_SNOOZE)) begin
          w_state_nxt      = StSnooze;
          w_sn_cnt_nxt     = '0;
          w_snooze_cnt_nxt = (r_snooze_cnt == 2'd3) ? 2'd3 : r_snooze_cnt + 2'd1;
`endif
        end else if (r_ring_cnt == RING_LAST) begin
          w_state_nxt = StIdle;
        end else begin
          w_ring_cnt_nxt = r_ring_cnt + RING_ONE;
        end
      end
      StSnooze: begin
`ifdef ALARM_SNOOZE_EN
        if (!i_alarm_en || w_stop_ev) begin
          w_state_nxt = StIdle;
        end else if (r_sn_cnt == SN_LAST) begin
          w_state_nxt    = StRinging;
          w_ring_cnt_nxt = '0;
        end else begin
          w_sn_cnt_nxt = r_sn_cnt + SN_ONE;
        end
`else
        w_state_nxt = StIdle;
`endif
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs decode from registered state only.
  always_comb begin
    o_state = r_state;
    o_ring  = (r_state == StRinging);
`ifdef ALARM_SNOOZE_EN
    o_snoozing   = (r_state == StSnooze);
    o_snooze_cnt = r_snooze_cnt;
`else
    o_snoozing   = 1'b0;
    o_snooze_cnt = 2'd0;
`endif
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl (RING_CYCLES=5, SNOOZE_CYCLES=4,
// MAX_SNOOZE=2). Snooze scenarios run when ALARM_SNOOZE_EN is defined, otherwise the
// snooze button is checked to have no effect.
module tb_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] now_v;
  logic [15:0] alm_v;
  logic        alarm_en;
  logic        stop_btn;
  logic        snooze_btn;
  logic        ring;
  logic        snoozing;
  logic [1:0]  state;
  logic [1:0]  snooze_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_ctrl #(
    .RING_CYCLES  (5),
    .SNOOZE_CYCLES(4),
    .MAX_SNOOZE   (2)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_hourdec_now(now_v[15:12]),
    .i_hourone_now(now_v[11:8]),
    .i_mindec_now (now_v[7:4]),
    .i_minone_now (now_v[3:0]),
    .i_hourdec_alm(alm_v[15:12]),
    .i_hourone_alm(alm_v[11:8]),
    .i_mindec_alm (alm_v[7:4]),
    .i_minone_alm (alm_v[3:0]),
    .i_alarm_en   (alarm_en),
    .i_stop_btn   (stop_btn),
    .i_snooze_btn (snooze_btn),
    .o_ring       (ring),
    .o_snoozing   (snoozing),
    .o_state      (state),
    .o_snooze_cnt (snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Approach 12:00 from 11:59 so the next edge sees a fresh match.
  task automatic trigger();
    now_v = 16'h1159;
    tick();
    now_v = 16'h1200;
    tick();
  endtask

  initial begin
    rstn       = 1'b0;
    now_v      = 16'h0730;
    alm_v      = 16'h0730;
    alarm_en   = 1'b1;
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    #2;
    check("rst_state", 32'(state), 0);
    check("rst_ring", 32'(ring), 0);
    check("rst_snzcnt", 32'(snooze_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
    check("no_ring_at_release", 32'(ring), 0);

    // Leave and re-enter the matching minute: ring one edge later, for exactly 5 cycles.
    now_v = 16'h0731;
    tick();
    now_v = 16'h0730;
    check("ring_before_edge", 32'(ring), 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ring_hold%0d", i), 32'(ring), 1);
      tick();
    end
    check("timeout_state", 32'(state), 0);
    check("timeout_ring", 32'(ring), 0);
    tick();
    tick();
    check("no_rering_0730", 32'(state), 0);

    // Stop button ends ringing on the next edge; holding 12:00 never re-rings.
    alm_v = 16'h1200;
    trigger();
    check("stop_ringing", 32'(state), 1);
    stop_btn = 1'b1;
    check("stop_pre_edge", 32'(ring), 1);
    tick();
    stop_btn = 1'b0;
    check("stop_ring", 32'(ring), 0);
    check("stop_state", 32'(state), 0);
    for (int i = 0; i < 8; i++) tick();
    check("stop_no_rering", 32'(ring), 0);

`ifdef ALARM_SNOOZE_EN
    // Snooze sequence: two snoozes honoured, the third ignored.
    trigger();
    check("snz_trig_cnt", 32'(snooze_cnt), 0);
    for (int s = 1; s <= 2; s++) begin
      snooze_btn = 1'b1;
      tick();
      snooze_btn = 1'b0;
      check($sformatf("snz%0d_state", s), 32'(state), 2);
      check($sformatf("snz%0d_cnt", s), 32'(snooze_cnt), 32'(s));
      for (int i = 0; i < 4; i++) begin
        check($sformatf("snz%0d_hold%0d", s, i), 32'(snoozing), 1);
        tick();
      end
      check($sformatf("snz%0d_resume", s), 32'(ring), 1);
      check($sformatf("snz%0d_off", s), 32'(snoozing), 0);
    end
    snooze_btn = 1'b1;
    tick();
    snooze_btn = 1'b0;
    check("snz3_ignored", 32'(state), 1);
    check("snz3_cnt", 32'(snooze_cnt), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("snz3_ring%0d", i), 32'(ring), 1);
    end
    tick();
    check("snz3_timeout", 32'(state), 0);

    // Disable during SNOOZE drops to IDLE; a match while disabled never rings.
    trigger();
    snooze_btn = 1'b1;
    tick();
    snooze_btn = 1'b0;
    check("dis_in_snooze", 32'(state), 2);
    alarm_en = 1'b0;
    tick();
    check("dis_idle", 32'(state), 0);
    trigger();
    check("dis_no_ring", 32'(state), 0);
    alarm_en = 1'b1;
    tick();
    check("dis_rise_lost", 32'(state), 0);

    // Stop and snooze in the same cycle: stop wins.
    trigger();
    stop_btn   = 1'b1;
    snooze_btn = 1'b1;
    tick();
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    check("both_state", 32'(state), 0);
    check("both_cnt", 32'(snooze_cnt), 0);
`else
    // Snooze button has no effect: ring runs to its timeout, snoozing stays low.
    trigger();
    snooze_btn = 1'b1;
    tick();
    snooze_btn = 1'b0;
    check("nosnz_ring", 32'(ring), 1);
    check("nosnz_snoozing", 32'(snoozing), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("nosnz_ring%0d", i), 32'(ring), 1);
      check($sformatf("nosnz_flag%0d", i), 32'(snoozing), 0);
    end
    tick();
    check("nosnz_timeout", 32'(state), 0);
    check("nosnz_cnt", 32'(snooze_cnt), 0);

    // Stop and snooze together while ringing.
    trigger();
    stop_btn   = 1'b1;
    snooze_btn = 1'b1;
    tick();
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    check("both_state", 32'(state), 0);

    // Disabled alarm never rings at a match.
    alarm_en = 1'b0;
    trigger();
    check("dis_no_ring", 32'(state), 0);
    alarm_en = 1'b1;
    tick();
    check("dis_rise_lost", 32'(state), 0);
`endif

    // Reset mid-ring drops ring asynchronously and the event is lost.
    trigger();
    tick();
    check("rst_mid_ringing", 32'(ring), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_ring", 32'(ring), 0);
    check("rst_mid_state", 32'(state), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
    check("rst_event_lost", 32'(ring), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
